// File: rtl/shift_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_pipe_stage
// Purpose  : Registered, handshaked shift execution stage for the multi-cycle
//            ALU path. One operand register (S1) feeds a combinational
//            sll/srl/sra shifter whose result is pushed into a 2-entry output
//            FIFO. Full throughput with back-pressure in both directions.
// Options  : SHIFT_ROTATE_EN - when defined, op 2'b11 is rotate-right;
//            otherwise op 2'b11 is illegal (result = in_a, out_err = 1).
// Ports    : clk        - clock, rising edge
//            nrst       - asynchronous active-low reset
//            flush      - synchronous kill of all in-flight ops
//            in_valid   - issue stage presents an op
//            in_ready   - stage accepts the op this cycle
//            in_a       - value to shift
//            in_b       - shift amount source (low SHAMT_W bits used)
//            in_op      - 00 sll, 01 srl, 10 sra, 11 rotate/illegal
//            in_tag     - opaque destination/ROB tag
//            out_valid  - output FIFO head is valid
//            out_ready  - consumer takes the head this cycle
//            out_result - shifted value at the head
//            out_tag    - tag of the head
//            out_zero   - head result is zero
//            out_err    - head op was illegal
// Revision : 1.0 - initial release
// ============================================================================
module shift_pipe_stage #(
  parameter int WIDTH   = 32,  // only 32 is supported
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_zero,
  output logic               out_err
);

  localparam logic [1:0]         c_OP_SLL   = 2'b00;
  localparam logic [1:0]         c_OP_SRL   = 2'b01;
  localparam logic [1:0]         c_OP_SRA   = 2'b10;
  localparam logic [1:0]         c_CNT_FULL = 2'd2;
  localparam logic [SHAMT_W:0]   c_ROT_BASE = (SHAMT_W+1)'(WIDTH);

  // S1 operand register
  logic               r_s1_valid;
  logic [WIDTH-1:0]   r_s1_a;
  logic [SHAMT_W-1:0] r_s1_shamt;
  logic [1:0]         r_s1_op;
  logic [TAG_W-1:0]   r_s1_tag;

  // Output FIFO storage
  logic [WIDTH-1:0]   r_fifo_result [2];
  logic [TAG_W-1:0]   r_fifo_tag    [2];
  logic               r_fifo_zero   [2];
  logic               r_fifo_err    [2];
  logic               r_rd_ptr;
  logic               r_wr_ptr;
  logic [1:0]         r_count;

  logic               w_pop;
  logic               w_s1_adv;
  logic               w_push;
  logic               w_accept;
  logic               w_head;
  logic [WIDTH-1:0]   w_result;
  logic               w_err;
  logic               w_unused_b;

  // Upper shift-amount bits are ignored by definition.
  assign w_unused_b = ^in_b[WIDTH-1:SHAMT_W];

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  assign out_valid = (r_count != 2'd0);
  assign w_pop     = out_valid && out_ready;
  // S1 can drain into the FIFO whenever a slot is free or one frees this cycle.
  assign w_s1_adv  = r_s1_valid && ((r_count != c_CNT_FULL) || w_pop);
  assign w_push    = w_s1_adv && !flush;
  // Gated by nrst so the stage never advertises ready while held in reset.
  assign in_ready  = nrst && (!r_s1_valid || w_s1_adv);
  assign w_accept  = in_valid && in_ready && !flush;

  // --------------------------------------------------------------------------
  // Shifter (combinational from S1)
  // --------------------------------------------------------------------------
  always_comb begin
    w_result = r_s1_a;
    w_err    = 1'b0;
    case (r_s1_op)
      c_OP_SLL: w_result = r_s1_a << r_s1_shamt;
      c_OP_SRL: w_result = r_s1_a >> r_s1_shamt;
      c_OP_SRA: w_result = $unsigned($signed(r_s1_a) >>> r_s1_shamt);
      default: begin
`ifdef SHIFT_ROTATE_EN
        // A left shift by WIDTH yields zero, so shamt 0 returns a unchanged.
        w_result = (r_s1_a >> r_s1_shamt) |
                   (r_s1_a << (c_ROT_BASE - {1'b0, r_s1_shamt}));
        w_err    = 1'b0;
`else
        w_result = r_s1_a;
        w_err    = 1'b1;
`endif
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // S1 register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_shamt <= '0;
      r_s1_op    <= '0;
      r_s1_tag   <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= in_a;
      r_s1_shamt <= in_b[SHAMT_W-1:0];
      r_s1_op    <= in_op;
      r_s1_tag   <= in_tag;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_fifo_result[0] <= '0;
      r_fifo_result[1] <= '0;
      r_fifo_tag[0]    <= '0;
      r_fifo_tag[1]    <= '0;
      r_fifo_zero[0]   <= 1'b0;
      r_fifo_zero[1]   <= 1'b0;
      r_fifo_err[0]    <= 1'b0;
      r_fifo_err[1]    <= 1'b0;
      r_rd_ptr         <= 1'b0;
      r_wr_ptr         <= 1'b0;
      r_count          <= 2'd0;
    end else if (flush) begin
      r_count <= 2'd0;
      // Step past the displayed entry so the empty-state view below keeps
      // showing the value that was on the outputs before the flush.
      if (r_count != 2'd0) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_wr_ptr <= ~r_rd_ptr;
      end
    end else begin
      if (w_push) begin
        r_fifo_result[r_wr_ptr] <= w_result;
        r_fifo_tag[r_wr_ptr]    <= r_s1_tag;
        r_fifo_zero[r_wr_ptr]   <= (w_result == '0);
        r_fifo_err[r_wr_ptr]    <= w_err;
        r_wr_ptr                <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // When empty, the most recently popped entry sits just behind the read
  // pointer; presenting it keeps the output data stable.
  assign w_head     = (r_count != 2'd0) ? r_rd_ptr : ~r_rd_ptr;
  assign out_result = r_fifo_result[w_head];
  assign out_tag    = r_fifo_tag[w_head];
  assign out_zero   = r_fifo_zero[w_head];
  assign out_err    = r_fifo_err[w_head];

endmodule
`default_nettype wire
